// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, reset/bubble
// constants and the IF/ID register layout.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'b00,
        FETCH_RUN   = 2'b01,
        FETCH_HOLD  = 2'b10,
        FETCH_DRAIN = 2'b11
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a word that arrived while decode was stalled.
// Clear wins over load so a redirect can never leak a stale word.
module fetch_skid_buffer
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] insn_i,
    output logic        full_o,
    output logic [31:0] pc_o,
    output logic [31:0] insn_o
);

    logic        full_q, full_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] insn_q, insn_d;

    // Next-state for the single skid entry
    always_comb begin
        full_d = full_q;
        pc_d   = pc_q;
        insn_d = insn_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            pc_d   = pc_i;
            insn_d = insn_i;
        end else begin
            full_d = full_q;
        end
    end

    // Skid entry storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            pc_q   <= 32'h0000_0000;
            insn_q <= NOP_INSN_DEF;
        end else begin
            full_q <= full_d;
            pc_q   <= pc_d;
            insn_q <= insn_d;
        end
    end

    assign full_o = full_q;
    assign pc_o   = pc_q;
    assign insn_o = insn_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage with IF/ID register: PC, req/ack fetch FSM, stall skid,
// and redirect handling that drains an unwithdrawable request before refetching.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] PC_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         req_q, req_d;
    ifid_t        ifid_q, ifid_d;

    logic         xfer_s;
    logic         take_mem_s;
    logic         take_skid_s;
    logic         bubble_s;
    logic         pc_inc_s;
    logic         skid_load_s;
    logic         skid_clear_s;
    logic         skid_full_s;
    logic [31:0]  skid_pc_s;
    logic [31:0]  skid_insn_s;
    logic         rpc_unused_s;

    assign xfer_s       = req_q & imem_ack;
    assign rpc_unused_s = ^redirect_pc_in[1:0];

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load_s),
        .clear_i (skid_clear_s),
        .pc_i    (pc_q),
        .insn_i  (imem_rdata),
        .full_o  (skid_full_s),
        .pc_o    (skid_pc_s),
        .insn_o  (skid_insn_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; a request without ack at a redirect edge must be drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (redirect_in) begin
                    state_d = xfer_s ? FETCH_RUN : FETCH_DRAIN;
                end else if (xfer_s && stall_in) begin
                    state_d = FETCH_HOLD;
                end else begin
                    state_d = FETCH_RUN;
                end
            end
            FETCH_HOLD: begin
                if (redirect_in || !stall_in) begin
                    state_d = FETCH_RUN;
                end else begin
                    state_d = FETCH_HOLD;
                end
            end
            FETCH_DRAIN: begin
                if (xfer_s) begin
                    state_d = FETCH_RUN;
                end else begin
                    state_d = FETCH_DRAIN;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // FSM outputs: datapath controls decoded from state and handshake
    always_comb begin
        take_mem_s   = 1'b0;
        take_skid_s  = 1'b0;
        bubble_s     = 1'b0;
        pc_inc_s     = 1'b0;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        req_d        = (state_d == FETCH_RUN) || (state_d == FETCH_DRAIN);
        if (redirect_in) begin
            bubble_s     = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            case (state_q)
                FETCH_RUN: begin
                    if (xfer_s) begin
                        pc_inc_s    = 1'b1;
                        skid_load_s = stall_in;
                        take_mem_s  = ~stall_in;
                    end else begin
                        bubble_s = ~stall_in;
                    end
                end
                FETCH_HOLD: begin
                    if (!stall_in) begin
                        take_skid_s  = skid_full_s;
                        skid_clear_s = 1'b1;
                    end else begin
                        take_skid_s = 1'b0;
                    end
                end
                FETCH_DRAIN: begin
                    bubble_s = ~stall_in;
                end
                default: begin
                    bubble_s = 1'b0;
                end
            endcase
        end
    end

    // PC, issued address and IF/ID next-state
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (redirect_in) begin
            pc_d = word_align(redirect_pc_in);
        end else if (pc_inc_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        // A draining request keeps its stale address on the bus until acked
        if (state_d == FETCH_DRAIN) begin
            addr_d = addr_q;
        end else begin
            addr_d = pc_d;
        end

        if (bubble_s) begin
            ifid_d = '{pc: ifid_q.pc, insn: NOP_INSN, valid: 1'b0};
        end else if (take_mem_s) begin
            ifid_d = '{pc: pc_q, insn: imem_rdata, valid: 1'b1};
        end else if (take_skid_s) begin
            ifid_d = '{pc: skid_pc_s, insn: skid_insn_s, valid: 1'b1};
        end else begin
            ifid_d = ifid_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            addr_q <= RESET_PC;
            req_q  <= 1'b0;
            ifid_q <= '{pc: 32'h0000_0000, insn: NOP_INSN, valid: 1'b0};
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
            req_q  <= req_d;
            ifid_q <= ifid_d;
        end
    end

    assign imem_req        = req_q;
    assign imem_addr       = addr_q;
    assign PC_out          = ifid_q.pc;
    assign instruction_out = ifid_q.insn;
    assign valid_out       = ifid_q.valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: variable-latency memory model, per-cycle vector table,
// and a PC-ordered scoreboard of the instructions decode should consume.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic [31:0] PC_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int          n_tests = 0;
    int          n_fail = 0;
    int          waits = 0;
    int          wcnt = 0;
    int          delivered = 0;
    logic [31:0] sbq[$];
    logic        st_e, ack_e, req_e;
    logic [31:0] addr_e;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[15];

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall_in        (stall_in),
        .redirect_in     (redirect_in),
        .redirect_pc_in  (redirect_pc_in),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_1003;
    endfunction

    // Memory model: acks after `waits` idle cycles, garbage data when not acking
    always @(negedge clk) begin
        if (reset || !imem_req) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            wcnt       = 0;
        end else begin
            if (imem_ack) wcnt = 0;
            if (wcnt >= waits) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                wcnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample #1 after posedge, consume IF/ID if not stalled
    task automatic cycle(input logic s, input logic r, input logic [31:0] rpc);
        logic [31:0] exp_pc;
        @(negedge clk);
        stall_in = s; redirect_in = r; redirect_pc_in = rpc;
        req_e = imem_req; addr_e = imem_addr;
        @(posedge clk);
        st_e = s; ack_e = imem_ack;
        #1;
        if (!reset) begin
            if (!valid_out) chk("bubble_nop", instruction_out, NOP);
            if (!st_e && valid_out) begin
                if (sbq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_extra: got pc %08h expected no instruction", PC_out);
                end else begin
                    exp_pc = sbq.pop_front();
                    chk("sb_pc", PC_out, exp_pc);
                    chk("sb_insn", instruction_out, mem_word(exp_pc));
                    delivered++;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = 32'h0;
        sbq.delete(); delivered = 0; waits = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_insn", instruction_out, NOP);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Zero-wait stream, 3-cycle stall with ack at 0x10, redirect+ack+stall to 0x103
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h00};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h04};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h08};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h0C};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h0C};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h0C};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h0C};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h10};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h018, 1'b1, 32'h14};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h01C, 1'b1, 32'h18};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b1, 32'h1C};
        tbl[12] = '{1'b1, 1'b1, 32'h103, 1'b1, 32'h100, 1'b0, 32'h1C};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};
        tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};

        do_reset();
        for (int a = 0; a < 32'h20; a += 4) sbq.push_back(32'(a));
        sbq.push_back(32'h100);
        sbq.push_back(32'h104);
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
            chk($sformatf("t%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("t%0d_valid", i), 32'(valid_out), 32'(tbl[i].exp_valid));
            chk($sformatf("t%0d_pc", i), PC_out, tbl[i].exp_pc);
        end
        chk("t_drain", 32'(sbq.size()), 32'd0);

        // Two wait states: address held, valid only on the ack edge, words in order
        do_reset();
        waits = 2;
        for (int a = 0; a <= 32'h24; a += 4) sbq.push_back(32'(a));
        for (int i = 0; i < 31; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            chk("w_valid", 32'(valid_out), 32'(ack_e));
            if (req_e && !ack_e && imem_req) chk("w_addr_stable", imem_addr, addr_e);
        end
        chk("w_count", 32'(delivered), 32'd10);
        chk("w_drain", 32'(sbq.size()), 32'd0);

        // Redirect to 0x200 while 0x24 is outstanding: drain, discard, refetch
        do_reset();
        for (int a = 0; a <= 32'h20; a += 4) sbq.push_back(32'(a));
        for (int k = 0; k < 50 && imem_addr !== 32'h24; k++) cycle(1'b0, 1'b0, 32'h0);
        chk("d_reach_24", imem_addr, 32'h24);
        waits = 2;
        sbq.push_back(32'h200);
        sbq.push_back(32'h204);
        cycle(1'b0, 1'b1, 32'h200);
        chk("d_addr_stale0", imem_addr, 32'h24);
        chk("d_req0", 32'(imem_req), 32'd1);
        chk("d_valid0", 32'(valid_out), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("d_addr_stale1", imem_addr, 32'h24);
        chk("d_valid1", 32'(valid_out), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("d_addr_target", imem_addr, 32'h200);
        chk("d_valid2", 32'(valid_out), 32'd0);
        waits = 0;
        cycle(1'b0, 1'b0, 32'h0);
        chk("d_pc_target", PC_out, 32'h200);
        cycle(1'b0, 1'b0, 32'h0);
        chk("d_drain", 32'(sbq.size()), 32'd0);

        // PC wrap at 0xFFFF_FFFC, then async reset in the middle of a request
        do_reset();
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("x_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("x_valid0", 32'(valid_out), 32'd0);
        sbq.push_back(32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0);
        chk("x_addr_wrap", imem_addr, 32'h0);
        chk("x_req_wrap", 32'(imem_req), 32'd1);
        chk("x_drain", 32'(sbq.size()), 32'd0);
        reset = 1'b1;
        #1;
        chk("x_async_req", 32'(imem_req), 32'd0);
        chk("x_async_valid", 32'(valid_out), 32'd0);
        chk("x_async_insn", instruction_out, NOP);
        chk("x_async_pc", PC_out, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.push_back(32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("x_restart_req", 32'(imem_req), 32'd1);
        chk("x_restart_addr", imem_addr, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("x_restart_valid", 32'(valid_out), 32'd1);
        chk("x_restart_drain", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
